// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and the holding-slot payload for the write-back arbiter.
//   FU_* : requester index of each functional unit
//   WB_SRC_NONE : wb_src value when no write-back happens
//   wb_slot_t : one holding slot {valid, rd, data}
package wb_pkg;

    localparam int unsigned WB_NUM_FU = 5;
    localparam int unsigned WB_XLEN   = 32;
    localparam int unsigned WB_RD_W   = 5;
    localparam int unsigned WB_SRC_W  = 3;

    localparam int unsigned FU_ALU  = 0;
    localparam int unsigned FU_MEM  = 1;
    localparam int unsigned FU_MUL  = 2;
    localparam int unsigned FU_DIV  = 3;
    localparam int unsigned FU_JUMP = 4;

    localparam logic [WB_SRC_W-1:0] WB_SRC_NONE = 3'd0;

    typedef struct packed {
        logic               valid;
        logic [WB_RD_W-1:0] rd;
        logic [WB_XLEN-1:0] data;
    } wb_slot_t;

endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: picks one requester, searching upward from ptr and wrapping.
//   req  : request vector
//   ptr  : first index examined (tie to 0 for fixed lowest-index priority)
//   gnt  : one-hot grant
//   idx  : encoded index of the granted requester (0 when none)
//   any  : a grant was issued
module wb_rr_picker #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First requester found walking ptr, ptr+1, ... modulo N.
    always_comb begin
        int unsigned p;
        logic [IW-1:0] pi;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        pi  = '0;
        for (int k = 0; k < int'(N); k++) begin
            p  = (32'(ptr) + 32'(k)) % N;
            pi = IW'(p);
            if (!any && req[pi]) begin
                gnt[pi] = 1'b1;
                idx     = pi;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port among the functional units.
// Each unit hands a result into a one-entry holding slot through valid/ready; one
// slot is granted per cycle and drives registered wb_en/wb_rd/wb_data/wb_src.
// Build option: define WB_RR_EN for round-robin arbitration (rr_ptr register);
// otherwise fixed priority, lowest index wins.
//   clk, rst   : clock, asynchronous active-high reset
//   fu_valid   : unit i presents a result
//   fu_rd      : destination register, 5 bits per unit
//   fu_data    : result data, XLEN bits per unit
//   fu_ready   : slot i can accept this cycle (combinational)
//   flush_mask : discard held and incoming results of the marked units
//   wb_en, wb_rd, wb_data : register-file write port
//   wb_src     : granted unit index + 1, 0 when no write
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_FU = WB_NUM_FU,
    parameter int unsigned XLEN   = WB_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*5-1:0]     fu_rd,
    input  logic [NUM_FU*XLEN-1:0]  fu_data,
    output logic [NUM_FU-1:0]       fu_ready,
    input  logic [NUM_FU-1:0]       flush_mask,
    output logic                    wb_en,
    output logic [4:0]              wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic [2:0]              wb_src
);

    localparam int unsigned IW = WB_SRC_W;

    wb_slot_t          slot_q [NUM_FU];
    logic [NUM_FU-1:0] hold_valid;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [IW-1:0]     pick_ptr;

    // Flushed slots are not candidates, so a flush also suppresses their grant.
    always_comb begin
        for (int i = 0; i < int'(NUM_FU); i++) begin
            hold_valid[i] = slot_q[i].valid;
        end
        req = hold_valid & ~flush_mask;
    end

    // A slot being granted this cycle may be refilled in the same cycle.
    assign fu_ready = ~{NUM_FU{rst}} & (~hold_valid | gnt);

`ifdef WB_RR_EN
    logic [IW-1:0] rr_ptr;

    assign pick_ptr = rr_ptr;

    // Search restarts just past the last winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == IW'(NUM_FU - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end
`else
    assign pick_ptr = '0;
`endif

    wb_rr_picker #(
        .N  (NUM_FU),
        .IW (IW)
    ) u_picker (
        .req (req),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Slot update: flush wins, then a fresh accept, then release on grant.
    // Results addressed to x0 complete the handshake but are never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_FU); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (flush_mask[i]) begin
                    slot_q[i].valid <= 1'b0;
                end else if (fu_valid[i] && fu_ready[i] && (fu_rd[i*5 +: 5] != 5'd0)) begin
                    slot_q[i].valid <= 1'b1;
                    slot_q[i].rd    <= fu_rd[i*5 +: 5];
                    slot_q[i].data  <= WB_XLEN'(fu_data[i*XLEN +: XLEN]);
                end else if (gnt[i]) begin
                    slot_q[i].valid <= 1'b0;
                end
            end
        end
    end

    // Registered write port; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_src  <= WB_SRC_NONE;
        end else if (gnt_any) begin
            wb_en   <= 1'b1;
            wb_rd   <= slot_q[gnt_idx].rd;
            wb_data <= XLEN'(slot_q[gnt_idx].data);
            wb_src  <= gnt_idx + IW'(1);
        end else begin
            wb_en   <= 1'b0;
            wb_src  <= WB_SRC_NONE;
        end
    end

endmodule
